// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one 8-bit RAM port among four requesters,
// with optional burst locking capped at MAX_BURST consecutive grants.
module dpram_port_arbiter #(
    parameter int DP        = 512,
    parameter int AW        = $clog2(DP) - 1,
    parameter int MAX_BURST = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          req,
    input  logic [3:0]          lock,
    input  logic [3:0]          wr,
    input  logic [4*(AW+1)-1:0] addr,
    input  logic [31:0]         wdata,
    output logic [3:0]          gnt,
    output logic [3:0]          rvalid,
    output logic [7:0]          rdata,
    output logic                locked,
    output logic                ram_en,
    output logic                ram_wr,
    output logic [AW:0]         ram_addr,
    output logic [7:0]          ram_din,
    input  logic [7:0]          ram_dout
);
    localparam int CW       = $clog2(MAX_BURST + 1);
    localparam bit BURST_EN = (MAX_BURST > 1);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t        fsm_q, fsm_d;
    logic [1:0]    prio_q, prio_d;
    logic [1:0]    owner_q, owner_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic [CW-1:0] burst_cnt_inc;
    logic [3:0]    rd_pend_q, rd_pend_d;

    logic [1:0]    start;
    logic [1:0]    idx;
    logic [1:0]    gidx;
    logic          found;
    logic          owner_hit;

    // Rotating search; a locked owner that still requests overrides it.
    always_comb begin
        owner_hit = (fsm_q == LOCKED) && req[owner_q];
        start     = (fsm_q == LOCKED) ? owner_q + 2'd1 : prio_q;
        found     = 1'b0;
        gidx      = start;
        idx       = start;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        if (owner_hit) begin
            found = 1'b1;
            gidx  = owner_q;
        end
    end

    always_comb begin
        gnt      = '0;
        ram_wr   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (found && !rst) begin
            gnt      = 4'b0001 << gidx;
            ram_wr   = wr[gidx];
            ram_addr = addr[gidx*(AW+1) +: (AW+1)];
            ram_din  = wdata[gidx*8 +: 8];
        end
    end

    assign ram_en = |gnt;
    assign rvalid = rd_pend_q;
    assign rdata  = ram_dout;
    assign locked = (fsm_q == LOCKED);

    assign burst_cnt_inc = burst_cnt_q + CW'(1);

    always_comb begin
        fsm_d       = fsm_q;
        prio_d      = prio_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        rd_pend_d   = gnt & ~wr;
        if (owner_hit) begin
            burst_cnt_d = burst_cnt_inc;
            if (!lock[owner_q] || burst_cnt_inc == CW'(MAX_BURST)) begin
                fsm_d       = IDLE;
                prio_d      = owner_q + 2'd1;
                burst_cnt_d = '0;
            end
        end else if (found) begin
            if (lock[gidx] && BURST_EN) begin
                fsm_d       = LOCKED;
                owner_d     = gidx;
                burst_cnt_d = CW'(1);
            end else begin
                fsm_d       = IDLE;
                prio_d      = gidx + 2'd1;
                burst_cnt_d = '0;
            end
        end else if (fsm_q == LOCKED) begin
            // Owner left with nobody else waiting: resume after the old owner.
            fsm_d       = IDLE;
            prio_d      = owner_q + 2'd1;
            burst_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            prio_q      <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            rd_pend_q   <= '0;
        end else begin
            fsm_q       <= fsm_d;
            prio_q      <= prio_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend_q   <= rd_pend_d;
        end
    end
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Scoreboard bench for dpram_port_arbiter: directed scenarios plus random
// requesters, checked against a queue-based reference arbiter and byte memory.
module tb_dpram_port_arbiter;
    localparam int DP  = 512;
    localparam int AW  = $clog2(DP) - 1;
    localparam int MB  = 4;
    localparam int BW  = 24;
    localparam int RW  = 12;

    logic                clk = 1'b0;
    logic                rst;
    logic [3:0]          req, lock, wr;
    logic [4*(AW+1)-1:0] addr;
    logic [31:0]         wdata;
    logic [3:0]          gnt, rvalid;
    logic [7:0]          rdata;
    logic                locked, ram_en, ram_wr;
    logic [AW:0]         ram_addr;
    logic [7:0]          ram_din;
    logic [7:0]          ram_dout;

    dpram_port_arbiter #(.DP(DP), .AW(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .wr(wr), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .locked(locked), .ram_en(ram_en), .ram_wr(ram_wr),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // ---------------- clock / reset / RAM environment ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [7:0] ram_mem [DP];
    initial begin
        for (int i = 0; i < DP; i++) ram_mem[i] = 8'h00;
        ram_dout = 8'h00;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr) ram_mem[ram_addr] <= ram_din;
            else        ram_dout <= ram_mem[ram_addr];
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [BW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    logic [RW-1:0] rd_exp_q[$];
    int            rd_cyc_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    // Monitor: pops the expected bus word for this cycle and any read return.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0 && exp_cyc_q[0] == cyc) begin
                void'(exp_cyc_q.pop_front());
                check("bus", 32'({gnt, ram_en, ram_wr, ram_addr, ram_din, locked}),
                      32'(exp_q.pop_front()));
            end
            if (rvalid != 4'b0 || (rd_cyc_q.size() > 0 && rd_cyc_q[0] == cyc)) begin
                if (rd_exp_q.size() == 0) begin
                    check("rvalid_unexpected", 32'(rvalid), 32'h0);
                end else begin
                    void'(rd_cyc_q.pop_front());
                    check("read", 32'({rvalid, rdata}), 32'(rd_exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- reference model ----------------
    int         m_prio, m_owner, m_cnt;
    bit         m_locked;
    logic [7:0] m_mem [DP];

    task automatic model_reset();
        m_prio = 0; m_owner = 0; m_cnt = 0; m_locked = 0;
    endtask

    function automatic int model_pick(input logic [3:0] r);
        int first;
        if (m_locked && r[m_owner]) return m_owner;
        first = m_locked ? (m_owner + 1) % 4 : m_prio;
        for (int k = 0; k < 4; k++)
            if (r[(first + k) % 4]) return (first + k) % 4;
        return -1;
    endfunction

    task automatic model_step(input int g, input logic [3:0] l);
        if (g < 0) begin
            if (m_locked) begin
                m_locked = 0; m_prio = (m_owner + 1) % 4; m_cnt = 0;
            end
        end else if (m_locked && g == m_owner) begin
            m_cnt++;
            if (!l[g] || m_cnt == MB) begin
                m_locked = 0; m_prio = (g + 1) % 4; m_cnt = 0;
            end
        end else if (l[g] && MB > 1) begin
            m_locked = 1; m_owner = g; m_cnt = 1;
        end else begin
            m_locked = 0; m_prio = (g + 1) % 4; m_cnt = 0;
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [3:0] w,
                         input logic [4*(AW+1)-1:0] a, input logic [31:0] d, output int g);
        logic [3:0] eg;
        logic       ew;
        logic [AW:0] ea;
        logic [7:0] ed;
        @(posedge clk); #1;
        req = r; lock = l; wr = w; addr = a; wdata = d;
        g  = model_pick(r);
        eg = '0; ew = 1'b0; ea = '0; ed = '0;
        if (g >= 0) begin
            eg = 4'b0001 << g;
            ew = w[g];
            ea = a[g*(AW+1) +: (AW+1)];
            ed = d[g*8 +: 8];
            if (ew) m_mem[ea] = ed;
            else begin
                rd_exp_q.push_back({eg, m_mem[ea]});
                rd_cyc_q.push_back(cyc + 1);
            end
        end
        exp_q.push_back({eg, (g >= 0), ew, ea, ed, m_locked});
        exp_cyc_q.push_back(cyc);
        model_step(g, l);
    endtask

    task automatic flush_and_reset_model();
        exp_q.delete(); exp_cyc_q.delete(); rd_exp_q.delete(); rd_cyc_q.delete();
        model_reset();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'h0);
        check({tag, "_ram_en"}, 32'(ram_en), 32'h0);
        check({tag, "_rvalid"}, 32'(rvalid), 32'h0);
        check({tag, "_locked"}, 32'(locked), 32'h0);
    endtask

    task automatic mid_reset();
        @(posedge clk); #1;
        req = 4'hf; lock = 4'h0; wr = 4'h0;
        #1 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        flush_and_reset_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; req = 4'h0; lock = 4'h0;
    endtask

    // ---------------- stimulus ----------------
    logic [3:0]          p_req, p_lock, p_wr;
    logic [4*(AW+1)-1:0] p_addr;
    logic [31:0]         p_data;
    logic [4*(AW+1)-1:0] a_v;
    int                  g;

    initial begin
        for (int i = 0; i < DP; i++) m_mem[i] = 8'h00;
        model_reset();
        rst = 1'b1; req = 4'hf; lock = 4'h0; wr = 4'h0; addr = '0; wdata = '0;
        #1 check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; req = 4'h0;

        // Write 0xA5 to addr 3 from requester 1, then read it back.
        a_v = '0; a_v[1*(AW+1) +: (AW+1)] = 9'd3;
        drive(4'b0010, 4'b0, 4'b0010, a_v, 32'h0000_A500, g);
        drive(4'b0010, 4'b0, 4'b0000, a_v, 32'h0, g);
        drive(4'b0000, 4'b0, 4'b0000, '0, 32'h0, g);

        // Round robin from prio 0.
        mid_reset();
        for (int i = 0; i < 4; i++) a_v[i*(AW+1) +: (AW+1)] = 9'(8 + i);
        for (int k = 0; k < 8; k++) drive(4'hf, 4'h0, 4'h0, a_v, 32'h4433_2211, g);

        // Burst cap: requester 0 locked, requester 1 waiting.
        for (int k = 0; k < 5; k++) drive(4'b0011, 4'b0001, 4'b0001, a_v, 32'h0000_77C0, g);

        // Early release: requester 2 locked, drops after two grants.
        drive(4'b1100, 4'b0100, 4'b0000, a_v, 32'h0, g);
        drive(4'b1100, 4'b0100, 4'b0000, a_v, 32'h0, g);
        drive(4'b1000, 4'b0000, 4'b0000, a_v, 32'h0, g);
        #1 check("early_release_gnt", 32'(gnt), 32'h8);
        drive(4'b0000, 4'b0000, 4'b0000, a_v, 32'h0, g);

        // Reset mid-burst with a read outstanding.
        drive(4'b0001, 4'b0001, 4'b0000, a_v, 32'h0, g);
        drive(4'b0001, 4'b0001, 4'b0000, a_v, 32'h0, g);
        mid_reset();
        drive(4'hf, 4'h0, 4'h0, a_v, 32'h0, g);
        #1 check("post_rst_first_gnt", 32'(gnt), 32'h1);
        drive(4'h0, 4'h0, 4'h0, a_v, 32'h0, g);

        // Random requesters honouring the hold-until-granted rule.
        p_req = '0; p_lock = '0; p_wr = '0; p_addr = '0; p_data = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!p_req[i] && $urandom_range(0, 99) < 35) begin
                    p_req[i]  = 1'b1;
                    p_lock[i] = ($urandom_range(0, 3) == 0);
                    p_wr[i]   = 1'($urandom_range(0, 1));
                    p_addr[i*(AW+1) +: (AW+1)] = 9'($urandom_range(0, 15));
                    p_data[i*8 +: 8] = 8'($urandom_range(0, 255));
                end
            end
            drive(p_req, p_lock, p_wr, p_addr, p_data, g);
            if (g >= 0) begin
                p_req[g] = p_lock[g] && ($urandom_range(0, 3) != 0);
                p_wr[g]  = 1'($urandom_range(0, 1));
                p_addr[g*(AW+1) +: (AW+1)] = 9'($urandom_range(0, 15));
                p_data[g*8 +: 8] = 8'($urandom_range(0, 255));
            end
        end

        for (int k = 0; k < 3; k++) drive(4'h0, 4'h0, 4'h0, '0, 32'h0, g);
        @(negedge clk); #1;
        check("drain", 32'(exp_q.size() + rd_exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
